// File: rtl/idex_reg.sv
// ID/EX pipeline register: captures the decoded control word and operands for the
// execute stage, with flush > stall > load priority, illegal ALU-op screening and a bubble counter.
module idex_reg #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall_e,
    input  logic             flush_e,
    input  logic             valid_d,
    input  logic             regwrite_d,
    input  logic             memtoreg_d,
    input  logic             memwrite_d,
    input  logic             alusrc_d,
    input  logic             regdst_d,
    input  logic             branch_d,
    input  logic [2:0]       alucontrol_d,
    input  logic [WIDTH-1:0] rd1_d,
    input  logic [WIDTH-1:0] rd2_d,
    input  logic [WIDTH-1:0] signimm_d,
    input  logic [WIDTH-1:0] pcplus4_d,
    input  logic [4:0]       rs_d,
    input  logic [4:0]       rt_d,
    input  logic [4:0]       rd_d,
    output logic             valid_e,
    output logic             regwrite_e,
    output logic             memtoreg_e,
    output logic             memwrite_e,
    output logic             alusrc_e,
    output logic             regdst_e,
    output logic             branch_e,
    output logic [2:0]       alucontrol_e,
    output logic [WIDTH-1:0] rd1_e,
    output logic [WIDTH-1:0] rd2_e,
    output logic [WIDTH-1:0] signimm_e,
    output logic [WIDTH-1:0] pcplus4_e,
    output logic [4:0]       rs_e,
    output logic [4:0]       rt_e,
    output logic [4:0]       rd_e,
    output logic             illegal_op,
    output logic [CNTW-1:0]  bubble_count
);

    typedef struct packed {
        logic             valid;
        logic             regwrite;
        logic             memtoreg;
        logic             memwrite;
        logic             alusrc;
        logic             regdst;
        logic             branch;
        logic [2:0]       alucontrol;
        logic [WIDTH-1:0] rd1;
        logic [WIDTH-1:0] rd2;
        logic [WIDTH-1:0] signimm;
        logic [WIDTH-1:0] pcplus4;
        logic [4:0]       rs;
        logic [4:0]       rt;
        logic [4:0]       rd;
    } ex_word_t;

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    ex_word_t e_q;
    ex_word_t d_word;
    logic     op_legal;
    logic     op_bad;

    always_comb begin
        op_legal = 1'b0;
        case (alucontrol_d)
            3'b010, 3'b110, 3'b000, 3'b001, 3'b111: op_legal = 1'b1;
            default:                                op_legal = 1'b0;
        endcase
    end

    assign op_bad = valid_d && !op_legal;

    // An illegal op still flows down the pipe, but with every architectural side effect removed.
    always_comb begin
        d_word            = '0;
        d_word.valid      = valid_d;
        d_word.regwrite   = regwrite_d && !op_bad;
        d_word.memtoreg   = memtoreg_d;
        d_word.memwrite   = memwrite_d && !op_bad;
        d_word.alusrc     = alusrc_d;
        d_word.regdst     = regdst_d;
        d_word.branch     = branch_d && !op_bad;
        d_word.alucontrol = alucontrol_d;
        d_word.rd1        = rd1_d;
        d_word.rd2        = rd2_d;
        d_word.signimm    = signimm_d;
        d_word.pcplus4    = pcplus4_d;
        d_word.rs         = rs_d;
        d_word.rt         = rt_d;
        d_word.rd         = rd_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_q          <= '0;
            illegal_op   <= 1'b0;
            bubble_count <= '0;
        end else begin
            if (flush_e) begin
                e_q <= '0;
            end else if (!stall_e) begin
                e_q <= d_word;
                if (op_bad) illegal_op <= 1'b1;
            end
            if (flush_e && bubble_count != CNT_MAX) bubble_count <= bubble_count + CNT_ONE;
        end
    end

    assign valid_e      = e_q.valid;
    assign regwrite_e   = e_q.regwrite;
    assign memtoreg_e   = e_q.memtoreg;
    assign memwrite_e   = e_q.memwrite;
    assign alusrc_e     = e_q.alusrc;
    assign regdst_e     = e_q.regdst;
    assign branch_e     = e_q.branch;
    assign alucontrol_e = e_q.alucontrol;
    assign rd1_e        = e_q.rd1;
    assign rd2_e        = e_q.rd2;
    assign signimm_e    = e_q.signimm;
    assign pcplus4_e    = e_q.pcplus4;
    assign rs_e         = e_q.rs;
    assign rt_e         = e_q.rt;
    assign rd_e         = e_q.rd;

endmodule

// File: tb/tb_idex_reg.sv
// Directed bench for idex_reg: reset, load, stall hold, flush priority,
// bubble saturation (CNTW=4) and illegal ALU-op screening.
module tb_idex_reg;

    localparam int WIDTH = 32;
    localparam int CNTW  = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             stall_e, flush_e, valid_d;
    logic             regwrite_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d, branch_d;
    logic [2:0]       alucontrol_d;
    logic [WIDTH-1:0] rd1_d, rd2_d, signimm_d, pcplus4_d;
    logic [4:0]       rs_d, rt_d, rd_d;
    logic             valid_e, regwrite_e, memtoreg_e, memwrite_e, alusrc_e, regdst_e, branch_e;
    logic [2:0]       alucontrol_e;
    logic [WIDTH-1:0] rd1_e, rd2_e, signimm_e, pcplus4_e;
    logic [4:0]       rs_e, rt_e, rd_e;
    logic             illegal_op;
    logic [CNTW-1:0]  bubble_count;

    int checks = 0;
    int errors = 0;

    idex_reg #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk(clk), .reset_n(reset_n), .stall_e(stall_e), .flush_e(flush_e), .valid_d(valid_d),
        .regwrite_d(regwrite_d), .memtoreg_d(memtoreg_d), .memwrite_d(memwrite_d),
        .alusrc_d(alusrc_d), .regdst_d(regdst_d), .branch_d(branch_d),
        .alucontrol_d(alucontrol_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .signimm_d(signimm_d),
        .pcplus4_d(pcplus4_d), .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
        .valid_e(valid_e), .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e),
        .memwrite_e(memwrite_e), .alusrc_e(alusrc_e), .regdst_e(regdst_e), .branch_e(branch_e),
        .alucontrol_e(alucontrol_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .signimm_e(signimm_e),
        .pcplus4_e(pcplus4_e), .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e),
        .illegal_op(illegal_op), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".ctrl"}, 64'({valid_e, regwrite_e, memtoreg_e, memwrite_e,
                                 alusrc_e, regdst_e, branch_e}), 64'd0);
        chk({tag, ".aluc"}, 64'(alucontrol_e), 64'd0);
        chk({tag, ".rd12"}, {rd1_e, rd2_e}, 64'd0);
        chk({tag, ".imm_pc"}, {signimm_e, pcplus4_e}, 64'd0);
        chk({tag, ".regs"}, 64'({rs_e, rt_e, rd_e}), 64'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        stall_e = 0; flush_e = 0; valid_d = 0;
        regwrite_d = 0; memtoreg_d = 0; memwrite_d = 0; alusrc_d = 0; regdst_d = 0; branch_d = 0;
        alucontrol_d = 3'b000;
        rd1_d = '0; rd2_d = '0; signimm_d = '0; pcplus4_d = '0;
        rs_d = '0; rt_d = '0; rd_d = '0;

        #3;
        chk_zero("reset0");
        chk("reset0.illegal", 64'(illegal_op), 64'd0);
        chk("reset0.bubble", 64'(bubble_count), 64'd0);

        @(negedge clk);
        reset_n = 1'b1;

        // load an add
        valid_d = 1; regwrite_d = 1; alucontrol_d = 3'b010; alusrc_d = 1;
        rd1_d = 32'h0000_0005; rd2_d = 32'h0000_0007; signimm_d = 32'hFFFF_FFF0;
        pcplus4_d = 32'h0000_0104; rs_d = 5'd3; rt_d = 5'd4; rd_d = 5'd5;
        step();
        chk("load.valid", 64'(valid_e), 64'd1);
        chk("load.regwrite", 64'(regwrite_e), 64'd1);
        chk("load.alusrc", 64'(alusrc_e), 64'd1);
        chk("load.aluc", 64'(alucontrol_e), 64'h2);
        chk("load.rd1", 64'(rd1_e), 64'h5);
        chk("load.rd2", 64'(rd2_e), 64'h7);
        chk("load.imm", 64'(signimm_e), 64'hFFFF_FFF0);
        chk("load.pc", 64'(pcplus4_e), 64'h104);
        chk("load.regs", 64'({rs_e, rt_e, rd_e}), 64'({5'd3, 5'd4, 5'd5}));

        // stall 3 cycles while D changes to a sub
        stall_e = 1; alucontrol_d = 3'b110; rd1_d = 32'hFFFF_FFFF; rs_d = 5'd9;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall.aluc", 64'(alucontrol_e), 64'h2);
            chk("stall.rd1", 64'(rd1_e), 64'h5);
            chk("stall.rs", 64'(rs_e), 64'd3);
        end
        stall_e = 0;
        step();
        chk("unstall.aluc", 64'(alucontrol_e), 64'h6);
        chk("unstall.rd1", 64'(rd1_e), 64'hFFFF_FFFF);
        chk("unstall.rs", 64'(rs_e), 64'd9);

        // flush beats stall
        stall_e = 1; flush_e = 1;
        step();
        chk_zero("flushstall");
        chk("flushstall.bubble", 64'(bubble_count), 64'd1);

        // saturation at 15
        stall_e = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk_zero("flushrun");
            chk("flushrun.bubble", 64'(bubble_count), 64'((i + 2 > 15) ? 15 : i + 2));
        end
        flush_e = 0;

        // illegal code on a non-valid slot is not screened
        valid_d = 0; alucontrol_d = 3'b011; regwrite_d = 1; memwrite_d = 1; branch_d = 1;
        memtoreg_d = 1;
        step();
        chk("nv.valid", 64'(valid_e), 64'd0);
        chk("nv.aluc", 64'(alucontrol_e), 64'h3);
        chk("nv.wr", 64'({regwrite_e, memwrite_e, branch_e}), 64'h7);
        chk("nv.illegal", 64'(illegal_op), 64'd0);
        chk("nv.bubble", 64'(bubble_count), 64'd15);

        // illegal code on a valid slot
        valid_d = 1;
        step();
        chk("ill.aluc", 64'(alucontrol_e), 64'h3);
        chk("ill.wr", 64'({regwrite_e, memwrite_e, branch_e}), 64'h0);
        chk("ill.memtoreg", 64'(memtoreg_e), 64'd1);
        chk("ill.illegal", 64'(illegal_op), 64'd1);

        // legal load afterwards: sticky flag stays
        alucontrol_d = 3'b111; memwrite_d = 0; branch_d = 0;
        step();
        chk("legal.aluc", 64'(alucontrol_e), 64'h7);
        chk("legal.regwrite", 64'(regwrite_e), 64'd1);
        chk("legal.illegal", 64'(illegal_op), 64'd1);

        // async reset mid-cycle with pending flush and stall
        stall_e = 1; flush_e = 1;
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("midreset");
        chk("midreset.illegal", 64'(illegal_op), 64'd0);
        chk("midreset.bubble", 64'(bubble_count), 64'd0);
        step();
        chk("heldreset.bubble", 64'(bubble_count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/idex_reg.md
# idex_reg

ID/EX pipeline register for the pipelined MIPS core. Captures the decode-stage control word (including the 3-bit ALU control produced by the ALU decoder), register operands, immediate and register specifiers, and presents them to the execute stage one cycle later. Supports hazard-unit stall (hold) and flush (bubble insertion), screens out illegal ALU control codes, and keeps a saturating count of inserted bubbles for performance debug.

## Interface

- WIDTH, 32, datapath width (operands, immediate, PC+4)
- CNTW, 16, bubble counter width

- clk  in  1  core clock, rising-edge
- reset_n  in  1  asynchronous, active-low reset
- stall_e  in  1  hold all E-stage contents this cycle
- flush_e  in  1  replace E-stage contents with a bubble this cycle
- valid_d  in  1  D-stage holds a real instruction
- regwrite_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d, branch_d  in  1 each  decoded control bits
- alucontrol_d  in  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt
- rd1_d, rd2_d  in  WIDTH  register-file read data
- signimm_d  in  WIDTH  sign-extended immediate
- pcplus4_d  in  WIDTH  PC+4 of the D-stage instruction
- rs_d, rt_d, rd_d  in  5 each  register specifiers
- valid_e, regwrite_e, memtoreg_e, memwrite_e, alusrc_e, regdst_e, branch_e  out  1 each  registered copies
- alucontrol_e  out  3  registered ALU op
- rd1_e, rd2_e, signimm_e, pcplus4_e  out  WIDTH  registered data
- rs_e, rt_e, rd_e  out  5 each  registered specifiers
- illegal_op  out  1  sticky: an illegal ALU code was captured
- bubble_count  out  CNTW  saturating count of flush-inserted bubbles

## Operation

- Three actions per rising edge, priority flush > stall > load.
- Flush: every E output cleared to 0 (control bits, valid_e, alucontrol_e=000, data, specifiers). Zero specifiers guarantee no forwarding match (register 0 excluded by forwarding logic).
- Stall (flush low): all E outputs hold; illegal_op and bubble_count unchanged.
- Load (neither): all E outputs take their _d inputs, with the illegal-op screen below.
- Illegal-op screen: on load with valid_d=1 and alucontrol_d not in {010,110,000,001,111}: regwrite_e, memwrite_e, branch_e forced 0; all other fields loaded as-is; illegal_op set to 1. illegal_op clears only on reset.
- Load with valid_d=0: fields loaded as-is, no screening, no illegal_op update; downstream qualifies on valid_e.
- bubble_count: +1 on every edge where flush_e=1, regardless of stall_e or existing contents; saturates at all-ones (2^CNTW-1), never wraps.

## Timing

- Reset (reset_n low, asynchronous, immediate): every output 0, including alucontrol_e=000, illegal_op=0, bubble_count=0. Release synchronous to next clk edge by upstream reset synchroniser; first load on first edge with reset_n high.
- Latency: D inputs at edge N visible on E outputs after edge N, stable through edge N+1.
- No combinational path input→output; all outputs are flop outputs.
- flush_e and stall_e both high: flush wins, counter increments.
- Stall held k cycles: outputs identical for k+1 cycles; D-stage inputs during stall ignored.
- Reset asserted mid-stall or mid-flush: reset wins immediately; pending action discarded.
- Counter at max with flush: stays at max.

## Test plan

- Reset: drive reset_n=0 mid-cycle with nonzero contents -> all outputs 0 immediately, bubble_count=0, illegal_op=0.
- Load: valid_d=1, regwrite_d=1, alucontrol_d=010, rd1_d=0x0000_0005, rs_d=3 -> after one edge valid_e=1, regwrite_e=1, alucontrol_e=010, rd1_e=0x5, rs_e=3.
- Stall: load add, assert stall_e 3 cycles while changing D inputs to sub/0xFFFF_FFFF -> E outputs remain add/0x5 for all 3 cycles, update to sub on first edge after stall drops.
- Flush priority: stall_e=1 and flush_e=1 together -> all E outputs 0, bubble_count 0→1; then CNTW=4, 20 consecutive flushes -> bubble_count saturates at 15.
- Illegal op: valid_d=1, alucontrol_d=011, regwrite_d=1, memwrite_d=1 -> alucontrol_e=011, regwrite_e=0, memwrite_e=0, illegal_op=1 and stays 1 after subsequent legal loads; same code with valid_d=0 -> illegal_op stays 0.
